// File: rtl/axi_pkg.sv
// Shared AXI read-path constants: burst encodings, arbiter FSM encoding,
// and a helper that picks the AR length for a latched request.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  // Line bursts use the per-cache line length; single beats always use 0.
  function automatic logic [7:0] ar_len_sel(input logic owner_d,
                                            input logic burst,
                                            input logic [7:0] i_len,
                                            input logic [7:0] d_len);
    logic [7:0] len;
    len = 8'd0;
    if (burst) len = owner_d ? d_len : i_len;
    return len;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the instruction side, bit 1 the
// data side. The priority pointer moves only when advance is pulsed, and
// then favours the side that was not granted.
module rr_arb2
  import axi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_hi;

  // Grant: a lone request wins outright; a tie goes to the pointer side.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio_hi ? 2'b10 : 2'b01;
  end

  // Pointer: after reset the data side wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_hi <= 1'b1;
    else if (advance) prio_hi <= grant[0];
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates instruction- and data-cache read requests onto one AXI read
// channel with a single outstanding transaction, and routes R beats back
// to the owning requester.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. arvalid, once raised, holds with stable payload
// until arready. rready is high only while collecting data. Requesters hold
// *_rd_req until their *_rd_rdy pulse (which coincides with the AR handshake).
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter logic [7:0] I_AXI_LEN = 8'd7,
  parameter logic [7:0] D_AXI_LEN = 8'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic [1:0]  i_rd_size,
  input  logic        i_rd_burst,
  output logic        i_rd_rdy,
  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  input  logic [1:0]  d_rd_size,
  input  logic        d_rd_burst,
  output logic        d_rd_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] ret_data,
  input  logic        wr_pending,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        len_err,
  output logic [1:0]  dbg_state
);

  logic [1:0]  state;
  logic [7:0]  beat_cnt;
  logic        owner_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        burst_q;

  logic [1:0]  arb_req;
  logic [1:0]  arb_grant;
  logic        grant_fire;
  logic        ar_fire;
  logic        beat;

  // The latched owner decides routing; the returned ID is not consulted.
  logic unused_rid;
  assign unused_rid = ^rid;

  assign dbg_state = state;

  // While a transaction is in flight the arbiter sees only the owner, so
  // its grant at the AR handshake names the side whose turn just ended.
  always_comb begin
    arb_req = {d_rd_req, i_rd_req};
    if (state != ST_IDLE) arb_req = {owner_d, ~owner_d};
  end

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (ar_fire),
    .grant   (arb_grant)
  );

  assign grant_fire = (state == ST_IDLE) && !wr_pending && (i_rd_req || d_rd_req);
  assign ar_fire    = arvalid && arready;
  assign beat       = rvalid && rready;

  // AR channel driven purely from latched request registers.
  assign arvalid = (state == ST_ADDR);
  assign arid    = {3'b000, owner_d};
  assign araddr  = addr_q;
  assign arlen   = ar_len_sel(owner_d, burst_q, I_AXI_LEN, D_AXI_LEN);
  assign arsize  = burst_q ? SIZE_WORD : {1'b0, size_q};
  assign arburst = burst_q ? BURST_INCR : BURST_FIXED;

  assign i_rd_rdy = ar_fire && !owner_d;
  assign d_rd_rdy = ar_fire &&  owner_d;

  // R channel: zero-latency routing to the owner only while collecting data.
  assign rready      = (state == ST_DATA);
  assign ret_data    = rdata;
  assign i_ret_valid = beat && !owner_d;
  assign i_ret_last  = beat && !owner_d && rlast;
  assign d_ret_valid = beat &&  owner_d;
  assign d_ret_last  = beat &&  owner_d && rlast;

  // Request capture; these registers are only meaningful after a grant.
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      owner_d <= arb_grant[1];
      addr_q  <= arb_grant[1] ? d_rd_addr  : i_rd_addr;
      size_q  <= arb_grant[1] ? d_rd_size  : i_rd_size;
      burst_q <= arb_grant[1] ? d_rd_burst : i_rd_burst;
    end
  end

  // Main FSM, beat counter and sticky burst-length error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      beat_cnt <= 8'd0;
      len_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (arready) begin
            state    <= ST_DATA;
            beat_cnt <= 8'd0;
          end
        end
        ST_DATA: begin
          if (rvalid) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (rlast && (beat_cnt != arlen)) len_err <= 1'b1;
            if (!rlast && (beat_cnt == arlen)) len_err <= 1'b1;
            if (rlast) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: scripted requesters and AXI slave, with a
// scoreboard holding expected AR descriptors and expected routed R beats.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_rd_req = 0, d_rd_req = 0;
  logic [31:0] i_rd_addr = 0, d_rd_addr = 0;
  logic [1:0]  i_rd_size = 0, d_rd_size = 0;
  logic        i_rd_burst = 0, d_rd_burst = 0;
  logic        i_rd_rdy, d_rd_rdy;
  logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
  logic [31:0] ret_data;
  logic        wr_pending = 0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 0;
  logic [3:0]  rid = 0;
  logic [31:0] rdata = 0;
  logic        rlast = 0, rvalid = 0;
  logic        rready, len_err;
  logic [1:0]  dbg_state;

  logic [63:0] exp_ar_q[$];
  logic [63:0] exp_r_q[$];
  int n_asserts = 0;
  int n_fail = 0;

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_size(i_rd_size),
    .i_rd_burst(i_rd_burst), .i_rd_rdy(i_rd_rdy),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_size(d_rd_size),
    .d_rd_burst(d_rd_burst), .d_rd_rdy(d_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
    .ret_data(ret_data), .wr_pending(wr_pending),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .len_err(len_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running, need finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference AR descriptor: {arid, araddr, arlen, arsize, arburst}
  function automatic logic [63:0] ar_word(input logic side_d, input logic [31:0] addr,
                                          input logic [1:0] size, input logic burst);
    logic [7:0] len;
    logic [2:0] sz;
    logic [1:0] bt;
    len = burst ? (side_d ? 8'd3 : 8'd7) : 8'd0;
    sz  = burst ? 3'b010 : {1'b0, size};
    bt  = burst ? 2'b01 : 2'b00;
    return {15'd0, 3'b000, side_d, addr, len, sz, bt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requester driver: raise one side's request and record its AR.
  task automatic set_req(input logic side_d, input logic [31:0] addr,
                         input logic [1:0] size, input logic burst);
    if (side_d) begin
      d_rd_req = 1; d_rd_addr = addr; d_rd_size = size; d_rd_burst = burst;
    end else begin
      i_rd_req = 1; i_rd_addr = addr; i_rd_size = size; i_rd_burst = burst;
    end
    exp_ar_q.push_back(ar_word(side_d, addr, size, burst));
  endtask

  // Slave AR side: wait for arvalid, stall 'delay' cycles, accept.
  task automatic ar_phase(input logic side_d, input logic [31:0] addr, input int delay);
    int n;
    n = 0;
    while (!arvalid && n < 50) begin step(); n++; end
    check_eq("arvalid_up", {63'd0, arvalid}, 64'd1);
    if (!arvalid) return;
    for (int k = 0; k < delay; k++) begin
      check_eq("araddr_hold", {32'd0, araddr}, {32'd0, addr});
      step();
    end
    arready = 1;
    step();
    arready = 0;
    if (side_d) d_rd_req = 0; else i_rd_req = 0;
  endtask

  // Slave R side: n beats, rlast on index last_at (stops there).
  task automatic beats(input logic side_d, input int n, input int last_at);
    for (int b = 0; b < n; b++) begin
      logic l;
      l = (b == last_at);
      rvalid = 1; rlast = l; rdata = $urandom; rid = $urandom_range(0, 15);
      exp_r_q.push_back({28'd0, !side_d, !side_d && l, side_d, side_d && l, rdata});
      step();
      if (l) break;
    end
    rvalid = 0; rlast = 0;
  endtask

  task automatic full_read(input logic side_d, input logic [31:0] addr,
                           input logic [1:0] size, input logic burst, input int delay);
    int n;
    set_req(side_d, addr, size, burst);
    ar_phase(side_d, addr, delay);
    n = burst ? (side_d ? 4 : 8) : 1;
    beats(side_d, n, n - 1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) check_eq("ar_unexpected", 64'd1, 64'd0);
        else begin
          logic [63:0] w;
          w = exp_ar_q.pop_front();
          check_eq("ar_desc", {15'd0, arid, araddr, arlen, arsize, arburst}, w);
          check_eq("rd_rdy", {62'd0, i_rd_rdy, d_rd_rdy}, {62'd0, !w[45], w[45]});
        end
      end else begin
        check_eq("rd_rdy_idle", {62'd0, i_rd_rdy, d_rd_rdy}, 64'd0);
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) check_eq("r_unexpected", 64'd1, 64'd0);
        else check_eq("r_route", {28'd0, i_ret_valid, i_ret_last, d_ret_valid, d_ret_last, ret_data},
                      exp_r_q.pop_front());
      end else begin
        check_eq("r_quiet", {60'd0, i_ret_valid, i_ret_last, d_ret_valid, d_ret_last}, 64'd0);
      end
    end
  end

  // Main stimulus
  initial begin
    step(); step();
    check_eq("reset_state", {54'd0, arvalid, rready, i_rd_rdy, d_rd_rdy, i_ret_valid,
             d_ret_valid, len_err, 1'b0, dbg_state}, 64'd0);
    reset = 0;
    step();

    // Instruction line burst with a 3-cycle AR stall.
    full_read(1'b0, 32'h1fc0_0000, 2'b10, 1'b1, 3);
    step();
    check_eq("len_err_ok", {63'd0, len_err}, 64'd0);
    check_eq("idle_after_burst", {62'd0, dbg_state}, 64'd0);

    // Ties: data wins after reset, then instruction, repeated.
    for (int r = 0; r < 2; r++) begin
      set_req(1'b1, 32'h0000_1000 + r, 2'b10, 1'b1);
      set_req(1'b0, 32'h0000_2000 + r, 2'b10, 1'b1);
      ar_phase(1'b1, 32'h0000_1000 + r, 0);
      beats(1'b1, 4, 3);
      ar_phase(1'b0, 32'h0000_2000 + r, 1);
      beats(1'b0, 8, 7);
    end

    // Write pending blocks a single-beat data read.
    wr_pending = 1;
    set_req(1'b1, 32'h1faf_f001, 2'b00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("wp_block", {63'd0, arvalid}, 64'd0);
    end
    wr_pending = 0;
    ar_phase(1'b1, 32'h1faf_f001, 0);
    beats(1'b1, 1, 0);

    // Random mix of requests.
    for (int t = 0; t < 4; t++) begin
      logic sd, bu;
      sd = 1'($urandom_range(0, 1));
      bu = 1'($urandom_range(0, 1));
      full_read(sd, $urandom & 32'hffff_fffc, 2'($urandom_range(0, 2)), bu, $urandom_range(0, 3));
    end
    check_eq("len_err_clean", {63'd0, len_err}, 64'd0);

    // R beat while idle is ignored.
    step();
    rvalid = 1; rdata = 32'hdead_beef; rlast = 1;
    #1;
    check_eq("idle_rready", {63'd0, rready}, 64'd0);
    check_eq("idle_no_route", {62'd0, i_ret_valid, d_ret_valid}, 64'd0);
    step();
    rvalid = 0; rlast = 0;

    // Data burst with early rlast sets the sticky error.
    set_req(1'b1, 32'h0000_4000, 2'b10, 1'b1);
    ar_phase(1'b1, 32'h0000_4000, 0);
    beats(1'b1, 2, 1);
    check_eq("len_err_set", {63'd0, len_err}, 64'd1);
    check_eq("idle_after_short", {62'd0, dbg_state}, 64'd0);
    step();
    check_eq("len_err_sticky", {63'd0, len_err}, 64'd1);

    // Reset during beat 3 of an instruction burst.
    set_req(1'b0, 32'h0000_8000, 2'b10, 1'b1);
    ar_phase(1'b0, 32'h0000_8000, 0);
    beats(1'b0, 2, 99);
    rvalid = 1; rdata = 32'h1234_5678;
    #1;
    reset = 1;
    #1;
    check_eq("reset_mid_data", {54'd0, arvalid, rready, i_rd_rdy, d_rd_rdy, i_ret_valid,
             d_ret_valid, i_ret_last, len_err, dbg_state}, 64'd0);
    rvalid = 0;
    @(posedge clk); #1;
    reset = 0;
    step();
    full_read(1'b1, 32'h0000_c000, 2'b10, 1'b1, 2);
    step();
    check_eq("post_reset_len_err", {63'd0, len_err}, 64'd0);

    check_eq("exp_ar_left", 64'(exp_ar_q.size()), 64'd0);
    check_eq("exp_r_left", 64'(exp_r_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
